// File: rtl/mat_mult_pkg.sv
// Shared types and constants for the Mat_mult byte-serial job sequencer.
package mat_mult_pkg;
   localparam int WORD_W = 32;
   localparam int NWORDS = 4;
   localparam int BUS_W  = WORD_W * NWORDS;
   localparam logic [7:0] HDR_M = 8'h4D;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_SEND} mms_state_t;

   // Byte idx of a bus, counted MSB-first (idx 0 = bits [BUS_W-1 -: 8]).
   function automatic logic [7:0] res_byte(input logic [BUS_W-1:0] v, input logic [3:0] idx);
      logic [BUS_W-1:0] s;
      s = v << {idx, 3'b000};
      return s[BUS_W-1 -: 8];
   endfunction
endpackage

// File: rtl/mat_mult_sequencer_if.sv
// Serial byte link and Mat_mult operand/result buses around the sequencer.
interface mat_mult_sequencer_if;
   import mat_mult_pkg::*;

   logic [7:0]       rx_data;
   logic             new_rx_data;
   logic [7:0]       tx_data;
   logic             new_tx_data;
   logic             tx_busy;
   logic [BUS_W-1:0] mm_a;
   logic [BUS_W-1:0] mm_b;
   logic [BUS_W-1:0] mm_res;

   modport master (
      output rx_data, new_rx_data, tx_busy, mm_res,
      input  tx_data, new_tx_data, mm_a, mm_b
   );

   modport slave (
      input  rx_data, new_rx_data, tx_busy, mm_res,
      output tx_data, new_tx_data, mm_a, mm_b
   );
endinterface

// File: rtl/mat_mult_sequencer_pacer.sv
// Streams a 16-byte result MSB-first, leaving a dead cycle after each strobe
// so the transmitter's one-cycle tx_busy lag is never violated.
module byte_tx_pacer
   import mat_mult_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [BUS_W-1:0] res_i,
   input  logic             tx_busy_i,
   output logic [7:0]       tx_data_o,
   output logic             new_tx_data_o,
   output logic             done_o
);
   logic [3:0] cnt_q, cnt_d;
   logic       stb_q, stb_d;
   logic [7:0] data_q, data_d;

   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      stb_d  = en_i & ~tx_busy_i & ~stb_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (stb_d) begin
         data_d = res_byte(res_i, cnt_q);
         cnt_d  = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         stb_q  <= 1'b0;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         stb_q  <= stb_d;
         data_q <= data_d;
      end
   end

   // The counter has wrapped back to 0 only once byte 15 has been strobed.
   assign done_o        = en_i & stb_q & (cnt_q == 4'd0);
   assign tx_data_o     = data_q;
   assign new_tx_data_o = stb_q;
endmodule

// File: rtl/mat_mult_sequencer.sv
// Byte-serial job controller: framed 32-byte operand load, latency wait,
// result capture and 16-byte result stream for the Mat_mult datapath.
module mat_mult_sequencer
   import mat_mult_pkg::*;
#(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned TIMEOUT = 50_000_000,
   parameter logic [7:0]  HDR     = HDR_M
) (
   input  logic                 clk,
   input  logic                 rst,
   mat_mult_sequencer_if.slave  bus,
   output logic                 busy,
   output logic                 err_timeout,
   output logic                 err_overrun,
   output logic [7:0]           jobs
);
   localparam int TW = $clog2(TIMEOUT + 1);

   mms_state_t         state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [2*BUS_W-1:0] shadow_q, shadow_d;
   logic [BUS_W-1:0]   mm_a_q, mm_a_d, mm_b_q, mm_b_d, res_q, res_d;
   logic [7:0]         wait_q, wait_d;
   logic [TW-1:0]      tmo_q, tmo_d;
   logic               busy_q, busy_d;
   logic               err_to_q, err_to_d, err_ov_q, err_ov_d;
   logic [7:0]         jobs_q, jobs_d;
   logic               tx_done;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      mm_a_d   = mm_a_q;
      mm_b_d   = mm_b_q;
      res_d    = res_q;
      wait_d   = wait_q;
      tmo_d    = tmo_q;
      err_to_d = err_to_q;
      err_ov_d = err_ov_q;
      jobs_d   = jobs_q;

      case (state_q)
         S_IDLE: begin
            if (bus.new_rx_data && bus.rx_data == HDR) begin
               state_d  = S_LOAD;
               cnt_d    = '0;
               tmo_d    = '0;
               err_to_d = 1'b0;
               err_ov_d = 1'b0;
            end
         end
         S_LOAD: begin
            // A byte in the same cycle as the timeout wins.
            if (bus.new_rx_data) begin
               shadow_d = {shadow_q[2*BUS_W-9:0], bus.rx_data};
               cnt_d    = cnt_q + 5'd1;
               tmo_d    = '0;
               if (cnt_q == 5'd31) begin
                  {mm_a_d, mm_b_d} = shadow_d;
                  wait_d  = 8'(LATENCY);
                  state_d = S_WAIT;
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (tmo_d == TW'(TIMEOUT)) begin
                  err_to_d = 1'b1;
                  state_d  = S_IDLE;
               end
            end
         end
         S_WAIT: begin
            if (wait_q == 8'd0) begin
               res_d   = bus.mm_res;
               state_d = S_SEND;
            end else begin
               wait_d = wait_q - 8'd1;
            end
         end
         S_SEND: begin
            if (tx_done) begin
               jobs_d  = jobs_q + 8'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if ((state_q == S_WAIT || state_q == S_SEND) && bus.new_rx_data)
         err_ov_d = 1'b1;

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         mm_a_q   <= '0;
         mm_b_q   <= '0;
         res_q    <= '0;
         wait_q   <= '0;
         tmo_q    <= '0;
         busy_q   <= 1'b0;
         err_to_q <= 1'b0;
         err_ov_q <= 1'b0;
         jobs_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         mm_a_q   <= mm_a_d;
         mm_b_q   <= mm_b_d;
         res_q    <= res_d;
         wait_q   <= wait_d;
         tmo_q    <= tmo_d;
         busy_q   <= busy_d;
         err_to_q <= err_to_d;
         err_ov_q <= err_ov_d;
         jobs_q   <= jobs_d;
      end
   end

   byte_tx_pacer u_pacer (
      .clk           (clk),
      .rst           (rst),
      .en_i          (state_q == S_SEND),
      .res_i         (res_q),
      .tx_busy_i     (bus.tx_busy),
      .tx_data_o     (bus.tx_data),
      .new_tx_data_o (bus.new_tx_data),
      .done_o        (tx_done)
   );

   assign bus.mm_a    = mm_a_q;
   assign bus.mm_b    = mm_b_q;
   assign busy        = busy_q;
   assign err_timeout = err_to_q;
   assign err_overrun = err_ov_q;
   assign jobs        = jobs_q;
endmodule
